// File: rtl/fetch_sequencer.sv
// Instruction fetch controller for the Aiva core.
// Reads a 24-bit instruction as three big-endian bytes from byte-wide program memory,
// hands it to the decoder on opcode/op_rdy, and advances pc when the decoder asserts pc_en.
// Optional feature: define FETCH_JUMP_EN to add jmp_valid/jmp_addr, which redirect pc from EXEC.

module fetch_sequencer #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [23:0]     opcode,
    output logic            op_rdy,
    input  logic            pc_en,
`ifdef FETCH_JUMP_EN
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_addr,
`endif
    output logic [PC_W-1:0] pc,
    output logic            busy
);

    typedef enum logic [2:0] {StIdle, StF0, StF1, StF2, StExec} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [23:0]     opcode_q, opcode_d;
    logic            req_q, req_d;
    logic            rdy_q, rdy_d;
    logic            busy_q, busy_d;

    logic            jump;
    logic [PC_W-1:0] jump_target;

`ifdef FETCH_JUMP_EN
    assign jump        = jmp_valid;
    assign jump_target = jmp_addr;
`else
    assign jump        = 1'b0;
    assign jump_target = '0;
`endif

    // Next-state logic: one byte per acknowledged read, then hold the instruction until released.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        opcode_d = opcode_q;
        req_d    = req_q;
        rdy_d    = rdy_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StF0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            StF0: begin
                if (mem_ack) begin
                    opcode_d[23:16] = mem_rdata;
                    addr_d          = pc_q + PC_W'(1);
                    state_d         = StF1;
                end
            end
            StF1: begin
                if (mem_ack) begin
                    opcode_d[15:8] = mem_rdata;
                    addr_d         = pc_q + PC_W'(2);
                    state_d        = StF2;
                end
            end
            StF2: begin
                if (mem_ack) begin
                    opcode_d[7:0] = mem_rdata;
                    req_d         = 1'b0;
                    rdy_d         = 1'b1;
                    state_d       = StExec;
                end
            end
            StExec: begin
                // A jump wins over a plain advance when both arrive together.
                if (jump) begin
                    pc_d    = jump_target;
                    addr_d  = jump_target;
                    rdy_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = StF0;
                end else if (pc_en) begin
                    pc_d    = pc_q + PC_W'(3);
                    addr_d  = pc_q + PC_W'(3);
                    rdy_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = StF0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset discards any partially fetched instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            opcode_q <= '0;
            req_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            opcode_q <= opcode_d;
            req_q    <= req_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign opcode   = opcode_q;
    assign op_rdy   = rdy_q;
    assign pc       = pc_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: random memory stalls and decoder delays against a
// transaction-level model (instruction = three bytes at pc, next pc = pc+3 or jump target).
// A second instance with RESET_PC=0xFFFE checks address wrap-around.

module tb_fetch_sequencer;

    logic        clk;
    logic        rst, run, mem_req, mem_ack, op_rdy, pc_en, busy;
    logic [15:0] mem_addr, pc;
    logic [7:0]  mem_rdata;
    logic [23:0] opcode;
`ifdef FETCH_JUMP_EN
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        w_jv;
    logic [15:0] w_ja;
`endif

    logic        rst_w, run_w, w_req, w_ack, w_rdy, w_pc_en, w_busy;
    logic [15:0] w_addr, w_pc;
    logic [7:0]  w_rdata;
    logic [23:0] w_opcode;

    logic [7:0]  mem [65536];

    int n_checks = 0;
    int n_pass   = 0;

    fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .op_rdy(op_rdy), .pc_en(pc_en),
`ifdef FETCH_JUMP_EN
        .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
`endif
        .pc(pc), .busy(busy)
    );

    fetch_sequencer #(.PC_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst(rst_w), .run(run_w),
        .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
        .opcode(w_opcode), .op_rdy(w_rdy), .pc_en(w_pc_en),
`ifdef FETCH_JUMP_EN
        .jmp_valid(w_jv), .jmp_addr(w_ja),
`endif
        .pc(w_pc), .busy(w_busy)
    );

    // Zero-wait memory for the wrap instance.
    assign w_ack   = w_req;
    assign w_rdata = mem[w_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [23:0] word_at(input logic [15:0] a);
        logic [15:0] a1, a2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        return {mem[a], mem[a1], mem[a2]};
    endfunction

    // Reference model state
    logic [15:0] exp_pc, exp_addr, jump_to, p_ja, ja;
    bit          fetching, exp_rdy, exp_req, fresh, reset_done, jump_now;
    bit          p_run, p_ack, p_pcen, p_jv, jv, go;
    int          byte_idx, wait_left, stalls, trig_edge, last_rise, edges, instrs;
    int          delay, exec_cnt;
    logic [15:0] q[$];
    logic [15:0] wexp[3];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h22;

        rst = 1'b1; rst_w = 1'b1; run = 1'b0; run_w = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00; pc_en = 1'b1; w_pc_en = 1'b0;
`ifdef FETCH_JUMP_EN
        jmp_valid = 1'b0; jmp_addr = 16'h0; w_jv = 1'b0; w_ja = 16'h0;
`endif
        #1 rst = 1'b0; rst_w = 1'b0;
        #1;
        check_eq("rst_op_rdy", 32'(op_rdy), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_opcode", 32'(opcode), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wrap_pc", 32'(w_pc), 32'hFFFE);

        @(negedge clk);
        rst = 1'b1;
        exp_pc = 16'h0; fetching = 0; byte_idx = 0; fresh = 1; wait_left = 0; stalls = 0;
        trig_edge = 0; last_rise = 0; edges = 0; instrs = 0; delay = 1; exec_cnt = 0;
        jump_now = 0; jump_to = 16'h0; reset_done = 0;
        p_run = 0; p_ack = 0; p_pcen = 0; p_jv = 0; p_ja = 16'h0;

        for (int c = 0; c < 4000 && instrs < 30; c++) begin
            // Account for what the previous clock edge did.
            if (!fetching) begin
                if (p_run) begin
                    fetching = 1; byte_idx = 0; trig_edge = edges; stalls = 0;
                end
            end else if (byte_idx < 3) begin
                if (p_ack) begin
                    byte_idx++;
                    if (byte_idx == 3) begin
                        instrs++;
                        check_eq("latency", 32'(edges - trig_edge + 1), 32'(4 + stalls));
                        if (instrs >= 2 && instrs <= 5)
                            check_eq("period", 32'(edges - last_rise), 32'd5);
                        last_rise = edges;
                        delay     = (instrs <= 8) ? 1 : int'($urandom_range(0, 3));
                        exec_cnt  = 0;
                        jump_now  = (instrs == 9) || (instrs > 9 && $urandom_range(0, 3) == 0);
                        jump_to   = (instrs == 9) ? 16'h0040 : 16'($urandom);
                    end
                end
            end else if (p_jv || p_pcen) begin
                exp_pc   = p_jv ? p_ja : exp_pc + 16'd3;
                byte_idx = 0; trig_edge = edges; stalls = 0;
            end

            exp_rdy  = fetching && byte_idx == 3;
            exp_req  = fetching && byte_idx < 3;
            exp_addr = exp_pc + 16'(byte_idx);
            check_eq("op_rdy", 32'(op_rdy), 32'(exp_rdy));
            check_eq("mem_req", 32'(mem_req), 32'(exp_req));
            check_eq("busy", 32'(busy), 32'(fetching));
            check_eq("pc", 32'(pc), 32'(exp_pc));
            if (exp_req) check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
            if (exp_rdy) check_eq("opcode", 32'(opcode), 32'(word_at(exp_pc)));

            // Asynchronous reset in the middle of the second byte fetch.
            if (instrs >= 20 && !reset_done && exp_req && byte_idx == 1) begin
                reset_done = 1;
                #1 rst = 1'b0;
                #1;
                check_eq("arst_op_rdy", 32'(op_rdy), 32'd0);
                check_eq("arst_mem_req", 32'(mem_req), 32'd0);
                check_eq("arst_pc", 32'(pc), 32'd0);
                check_eq("arst_busy", 32'(busy), 32'd0);
                check_eq("arst_opcode", 32'(opcode), 32'd0);
                check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
                #1 rst = 1'b1;
                fetching = 0; byte_idx = 0; exp_pc = 16'h0; fresh = 1; wait_left = 0;
                exp_req = 0; exp_rdy = 0;
            end

            // Memory: pick a stall per request, then return the byte at the requested address.
            if (exp_req) begin
                if (fresh) begin
                    if (instrs < 5)      wait_left = 0;
                    else if (instrs < 8) wait_left = (byte_idx == 1) ? 3 : 0;
                    else                 wait_left = int'($urandom_range(0, 2));
                    fresh = 0;
                end
                if (wait_left > 0) begin
                    mem_ack = 1'b0; mem_rdata = 8'($urandom); wait_left--; stalls++;
                end else begin
                    mem_ack = 1'b1; mem_rdata = mem[mem_addr]; fresh = 1;
                end
            end else begin
                mem_ack = 1'($urandom); mem_rdata = 8'($urandom);
            end

            // Decoder: pc_en high whenever op_rdy is low, else after its decode delay.
            if (op_rdy) begin
                go = exec_cnt >= delay;
                exec_cnt++;
                pc_en = go;
                jv = go && jump_now;
                ja = jump_to;
            end else begin
                pc_en = 1'b1;
                jv = 1'($urandom);
                ja = 16'($urandom);
            end
`ifdef FETCH_JUMP_EN
            jmp_valid = jv;
            jmp_addr  = ja;
`else
            jv = 1'b0;
`endif
            run = (c >= 3);

            p_run = run; p_ack = mem_ack; p_pcen = pc_en; p_jv = jv; p_ja = ja;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_eq("instr_count", 32'(instrs), 32'd30);

        // Wrap-around instance: 0xFFFE, 0xFFFF, 0x0000, then pc 0x0001.
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000;
        rst_w = 1'b1; run_w = 1'b1;
        q.delete();
        for (int k = 0; k < 20 && !w_rdy; k++) begin
            if (w_req) q.push_back(w_addr);
            @(negedge clk);
        end
        check_eq("wrap_rdy", 32'(w_rdy), 32'd1);
        check_eq("wrap_nfetch", 32'(q.size()), 32'd3);
        for (int i = 0; i < q.size() && i < 3; i++) check_eq("wrap_addr", 32'(q[i]), 32'(wexp[i]));
        check_eq("wrap_pc", 32'(w_pc), 32'hFFFE);
        check_eq("wrap_opcode", 32'(w_opcode), 32'(word_at(16'hFFFE)));

        w_pc_en = 1'b1;
        @(negedge clk);
        wexp[0] = 16'h0001; wexp[1] = 16'h0002; wexp[2] = 16'h0003;
        q.delete();
        for (int k = 0; k < 20 && !w_rdy; k++) begin
            if (w_req) q.push_back(w_addr);
            @(negedge clk);
        end
        check_eq("wrap2_rdy", 32'(w_rdy), 32'd1);
        check_eq("wrap2_nfetch", 32'(q.size()), 32'd3);
        for (int i = 0; i < q.size() && i < 3; i++) check_eq("wrap2_addr", 32'(q[i]), 32'(wexp[i]));
        check_eq("wrap2_pc", 32'(w_pc), 32'h0001);
        check_eq("wrap2_opcode", 32'(w_opcode), 32'(word_at(16'h0001)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
